// File: rtl/fft8_bf_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft8_bf_sched : 8-point radix-2 DIT FFT frame sequencer driving one
//                 external butterfly datapath.           Rev 1.0
// ---------------------------------------------------------------------------
module fft8_bf_sched #(
    parameter int N = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2**N-1:0]  in_r,
    input  logic [2**N-1:0]  in_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2**N-1:0]  out_r,
    output logic [2**N-1:0]  out_i,
    output logic [2:0]       out_idx,
    output logic             bf_en,
    output logic [1:0]       bf_tw,
    output logic [2**N-1:0]  bf_in_1_r,
    output logic [2**N-1:0]  bf_in_1_i,
    output logic [2**N-1:0]  bf_in_2_r,
    output logic [2**N-1:0]  bf_in_2_i,
    input  logic [2**N-1:0]  bf_out_1_r,
    input  logic [2**N-1:0]  bf_out_1_i,
    input  logic [2**N-1:0]  bf_out_2_r,
    input  logic [2**N-1:0]  bf_out_2_i,
    output logic             busy,
    output logic             frame_done
);
    localparam int W = 2**N;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        UNLOAD  = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic         armed;
    logic [2:0]   in_cnt;
    logic [2:0]   out_cnt;
    logic [3:0]   bf_cnt;
    logic [W-1:0] mem_r [8];
    logic [W-1:0] mem_i [8];
    logic [1:0]   stage;
    logic [1:0]   bidx;
    logic [2:0]   lo_addr;
    logic [2:0]   hi_addr;
    logic [1:0]   tw_sched;
    logic [2:0]   in_addr;
    logic         in_fire;
    logic         out_fire;

    assign stage   = bf_cnt[3:2];
    assign bidx    = bf_cnt[1:0];
    assign in_addr = {in_cnt[0], in_cnt[1], in_cnt[2]};

    // Butterfly b of stage s pairs lo with lo + 2^s; twiddle stride shrinks per stage.
    always_comb begin
        lo_addr  = 3'd0;
        hi_addr  = 3'd0;
        tw_sched = 2'd0;
        case (stage)
            2'd0: begin
                lo_addr  = {bidx, 1'b0};
                hi_addr  = {bidx, 1'b1};
                tw_sched = 2'd0;
            end
            2'd1: begin
                lo_addr  = {bidx[1], 1'b0, bidx[0]};
                hi_addr  = {bidx[1], 1'b1, bidx[0]};
                tw_sched = {bidx[0], 1'b0};
            end
            default: begin
                lo_addr  = {1'b0, bidx};
                hi_addr  = {1'b1, bidx};
                tw_sched = bidx;
            end
        endcase
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        bf_en      = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        in_fire    = 1'b0;
        out_fire   = 1'b0;
        case (state)
            LOAD: begin
                in_ready = armed;
                in_fire  = in_valid && armed;
                if (in_fire && (in_cnt == 3'd7)) begin
                    state_nxt = COMPUTE;
                end
            end
            COMPUTE: begin
                bf_en = 1'b1;
                busy  = 1'b1;
                if (bf_cnt == 4'd11) begin
                    state_nxt = UNLOAD;
                end
            end
            UNLOAD: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_fire  = out_ready;
                if (out_fire && (out_cnt == 3'd7)) begin
                    frame_done = 1'b1;
                    state_nxt  = LOAD;
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= LOAD;
            armed   <= 1'b0;
            in_cnt  <= 3'd0;
            out_cnt <= 3'd0;
            bf_cnt  <= 4'd0;
            for (int a = 0; a < 8; a++) begin
                mem_r[a] <= '0;
                mem_i[a] <= '0;
            end
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
            if (in_fire) begin
                mem_r[in_addr] <= in_r;
                mem_i[in_addr] <= in_i;
                in_cnt         <= in_cnt + 3'd1;
            end
            // In-place write-back; a stage never reads a location it already rewrote.
            if (state == COMPUTE) begin
                mem_r[lo_addr] <= bf_out_1_r;
                mem_i[lo_addr] <= bf_out_1_i;
                mem_r[hi_addr] <= bf_out_2_r;
                mem_i[hi_addr] <= bf_out_2_i;
                bf_cnt         <= (bf_cnt == 4'd11) ? 4'd0 : bf_cnt + 4'd1;
            end
            if (out_fire) begin
                out_cnt <= out_cnt + 3'd1;
            end
        end
    end

    assign out_r     = (state == UNLOAD)  ? mem_r[out_cnt] : '0;
    assign out_i     = (state == UNLOAD)  ? mem_i[out_cnt] : '0;
    assign out_idx   = (state == UNLOAD)  ? out_cnt        : 3'd0;
    assign bf_tw     = (state == COMPUTE) ? tw_sched       : 2'd0;
    assign bf_in_1_r = (state == COMPUTE) ? mem_r[lo_addr] : '0;
    assign bf_in_1_i = (state == COMPUTE) ? mem_i[lo_addr] : '0;
    assign bf_in_2_r = (state == COMPUTE) ? mem_r[hi_addr] : '0;
    assign bf_in_2_i = (state == COMPUTE) ? mem_i[hi_addr] : '0;

endmodule
`default_nettype wire
